// File: rtl/cnt_sched.sv
// Round-robin scheduler that time-shares one up/down counter among NREQ requesters.
// Each job loads the counter, runs it for a number of steps and reports the final count and rollovers.
module cnt_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int LENW  = 8,
  parameter int WRAPW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_load,
  input  logic [NREQ-1:0]       req_down,
  input  logic [NREQ*LENW-1:0]  req_len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      res_count,
  output logic [WRAPW-1:0]      res_wraps,
  output logic                  busy,
  output logic                  cnt_load_en,
  output logic [WIDTH-1:0]      cnt_load,
  output logic                  cnt_down,
  input  logic [WIDTH-1:0]      cnt_count,
  input  logic                  cnt_rollover
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [IDXW-1:0]  owner_q,     owner_d;
  logic [IDXW-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [WIDTH-1:0] job_load_q,  job_load_d;
  logic             job_down_q,  job_down_d;
  logic [LENW-1:0]  job_len_q,   job_len_d;
  logic [LENW-1:0]  rem_q,       rem_d;
  logic [WRAPW-1:0] wraps_q,     wraps_d;
  logic [NREQ-1:0]  gnt_q,       gnt_d;
  logic [NREQ-1:0]  done_q,      done_d;
  logic [WIDTH-1:0] res_count_q, res_count_d;
  logic [WRAPW-1:0] res_wraps_q, res_wraps_d;
  logic             busy_q,      busy_d;

  logic [IDXW-1:0]  pick;
  logic             pick_vld;
  int               pick_i;

  // First pending requester at or after rr_ptr, scanning cyclically.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = IDXW'(idx);
      end
    end
  end

  assign pick_i = int'(pick);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    job_load_d  = job_load_q;
    job_down_d  = job_down_q;
    job_len_d   = job_len_q;
    rem_d       = rem_q;
    wraps_d     = wraps_q;
    gnt_d       = '0;
    done_d      = '0;
    res_count_d = res_count_q;
    res_wraps_d = res_wraps_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d       = S_LOAD;
          owner_d       = pick;
          job_load_d    = req_load[pick_i*WIDTH +: WIDTH];
          job_down_d    = req_down[pick_i];
          job_len_d     = req_len[pick_i*LENW +: LENW];
          gnt_d[pick_i] = 1'b1;
        end
      end
      S_LOAD: begin
        rem_d   = job_len_q;
        wraps_d = '0;
        if (job_len_q != '0) begin
          state_d = S_RUN;
        end else begin
          state_d         = S_DONE;
          done_d[owner_q] = 1'b1;
        end
      end
      S_RUN: begin
        rem_d = rem_q - LENW'(1);
        if (cnt_rollover && (wraps_q != '1)) wraps_d = wraps_q + WRAPW'(1);
        if (rem_q == LENW'(1)) begin
          state_d         = S_DONE;
          done_d[owner_q] = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        res_count_d = cnt_count;
        res_wraps_d = wraps_q;
        rr_ptr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + IDXW'(1);
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Outside LOAD/RUN the counter reloads its own value, which freezes it.
  always_comb begin
    cnt_load_en = 1'b1;
    cnt_load    = cnt_count;
    cnt_down    = 1'b0;
    case (state_q)
      S_LOAD: begin
        cnt_load = job_load_q;
        cnt_down = job_down_q;
      end
      S_RUN: begin
        cnt_load_en = 1'b0;
        cnt_down    = job_down_q;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      job_load_q  <= '0;
      job_down_q  <= 1'b0;
      job_len_q   <= '0;
      rem_q       <= '0;
      wraps_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      res_count_q <= '0;
      res_wraps_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      job_load_q  <= job_load_d;
      job_down_q  <= job_down_d;
      job_len_q   <= job_len_d;
      rem_q       <= rem_d;
      wraps_q     <= wraps_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      res_count_q <= res_count_d;
      res_wraps_q <= res_wraps_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign res_count = res_count_q;
  assign res_wraps = res_wraps_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cnt_sched.sv
// Testbench for cnt_sched: behavioural up/down counter plus directed and randomized job scenarios.
// Expected results come from arithmetic on each job and the round-robin order rule.
module tb_cnt_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int LENW  = 8;
  localparam int WRAPW = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_load;
  logic [NREQ-1:0]       req_down;
  logic [NREQ*LENW-1:0]  req_len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      res_count;
  logic [WRAPW-1:0]      res_wraps;
  logic                  busy;
  logic                  cnt_load_en;
  logic [WIDTH-1:0]      cnt_load;
  logic                  cnt_down;
  logic [WIDTH-1:0]      cnt_count;
  logic                  cnt_rollover;

  int n_vec = 0;
  int n_err = 0;

  cnt_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LENW(LENW), .WRAPW(WRAPW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_load(req_load), .req_down(req_down),
    .req_len(req_len), .gnt(gnt), .done(done), .res_count(res_count),
    .res_wraps(res_wraps), .busy(busy), .cnt_load_en(cnt_load_en),
    .cnt_load(cnt_load), .cnt_down(cnt_down), .cnt_count(cnt_count),
    .cnt_rollover(cnt_rollover)
  );

  always #5 clk = ~clk;

  // Model of counter_ud; rollover flags the step that wraps.
  logic [WIDTH-1:0] ctr = '0;
  always @(posedge clk) begin
    if (cnt_load_en)   ctr <= cnt_load;
    else if (cnt_down) ctr <= ctr - 1'b1;
    else               ctr <= ctr + 1'b1;
  end
  assign cnt_count    = ctr;
  assign cnt_rollover = !cnt_load_en && (cnt_down ? (ctr == '0) : (ctr == '1));

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick_rr(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic void job_result(input int ld, input bit dn, input int len,
                                     output logic [WIDTH-1:0] c, output logic [WRAPW-1:0] w);
    int m, wr, wmax;
    m    = 1 << WIDTH;
    wmax = (1 << WRAPW) - 1;
    if (!dn) begin
      c  = WIDTH'((ld + len) % m);
      wr = (ld + len) / m;
    end else begin
      c  = WIDTH'((((ld - len) % m) + m) % m);
      wr = (len > ld) ? (len - ld - 1) / m + 1 : 0;
    end
    w = (wr > wmax) ? WRAPW'(wmax) : WRAPW'(wr);
  endfunction

  task automatic set_job(input int i, input logic [WIDTH-1:0] ld, input logic dn, input int len);
    req_load[i*WIDTH +: WIDTH] = ld;
    req_down[i]                = dn;
    req_len[i*LENW +: LENW]    = LENW'(len);
    req[i]                     = 1'b1;
  endtask

  task automatic wait_gnt(output int cyc, output logic [NREQ-1:0] g);
    g = '0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        cyc = c;
        g   = gnt;
        return;
      end
    end
    cyc = -1;
  endtask

  task automatic wait_done(output int cyc, output logic [NREQ-1:0] d);
    d = '0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (done != '0) begin
        cyc = c;
        d   = done;
        return;
      end
    end
    cyc = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One job from an idle scheduler; expected values are supplied by the caller.
  task automatic run_one(input string nm, input int i, input logic [WIDTH-1:0] ld, input logic dn,
                         input int len, input logic [WIDTH-1:0] exp_c, input logic [WRAPW-1:0] exp_w);
    int c;
    logic [NREQ-1:0] v;
    set_job(i, ld, dn, len);
    wait_gnt(c, v);
    n_vec++;
    if (c !== 1 || v !== onehot(i)) begin
      n_err++;
      $display("FAIL %s gnt: cycle %0d vec %b, expected cycle 1 vec %b", nm, c, v, onehot(i));
    end
    req[i] = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_in_job: got %b expected 1", nm, busy);
    end
    wait_done(c, v);
    n_vec++;
    if (c !== len + 1 || v !== onehot(i)) begin
      n_err++;
      $display("FAIL %s done: %0d cycles after gnt vec %b, expected %0d vec %b", nm, c, v, len + 1, onehot(i));
    end
    @(negedge clk);
    n_vec++;
    if (res_count !== exp_c) begin
      n_err++;
      $display("FAIL %s res_count: got %h expected %h", nm, res_count, exp_c);
    end
    n_vec++;
    if (res_wraps !== exp_w) begin
      n_err++;
      $display("FAIL %s res_wraps: got %h expected %h", nm, res_wraps, exp_w);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_after: got %b expected 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (gnt !== '0 || done !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: gnt %b done %b busy %b, expected all 0", gnt, done, busy);
    end
    n_vec++;
    if (res_count !== '0 || res_wraps !== '0) begin
      n_err++;
      $display("FAIL reset_res: count %h wraps %h, expected 0 0", res_count, res_wraps);
    end
    n_vec++;
    if (cnt_load_en !== 1'b1 || cnt_load !== cnt_count || cnt_down !== 1'b0) begin
      n_err++;
      $display("FAIL reset_cnt: load_en %b load %h down %b, expected 1 %h 0", cnt_load_en, cnt_load, cnt_down, cnt_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    run_one("up_wrap", 1, 4'hE, 1'b0, 4, 4'h2, 4'h1);
  endtask

  task automatic test_down_wrap();
    run_one("down_wrap", 0, 4'h1, 1'b1, 3, 4'hE, 4'h1);
  endtask

  task automatic test_zero_len();
    logic stable;
    run_one("zero_len", 2, 4'h7, 1'b0, 0, 4'h7, 4'h0);
    stable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cnt_count !== 4'h7) stable = 1'b0;
    end
    n_vec++;
    if (!stable) begin
      n_err++;
      $display("FAIL zero_len_idle_hold: counter %h, expected held at 7", cnt_count);
    end
  endtask

  task automatic test_round_robin();
    int k, res_at, res_own;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_job(i, WIDTH'(i * 4 + 1), 1'b0, 1);
    k      = 0;
    res_at = -1;
    res_own = 0;
    for (int c = 1; c <= 4 * NREQ + 1; c++) begin
      @(negedge clk);
      if (c == res_at) begin
        n_vec++;
        if (res_count !== WIDTH'(res_own * 4 + 2)) begin
          n_err++;
          $display("FAIL rr_res owner %0d: got %h expected %h", res_own, res_count, WIDTH'(res_own * 4 + 2));
        end
      end
      if (done != '0) begin
        res_at = c + 1;
        res_own = pick_rr(done, 0);
      end
      if (gnt != '0) begin
        n_vec++;
        if (gnt !== onehot(k % NREQ) || c !== 1 + 4 * k) begin
          n_err++;
          $display("FAIL rr_order job %0d: gnt %b at cycle %0d, expected %b at cycle %0d", k, gnt, c, onehot(k % NREQ), 1 + 4 * k);
        end
        req = req & ~gnt;
        k++;
      end
    end
    n_vec++;
    if (k !== NREQ) begin
      n_err++;
      $display("FAIL rr_count: %0d grants, expected %0d", k, NREQ);
    end
  endtask

  task automatic test_saturate();
    run_one("saturate", 0, 4'h0, 1'b0, 255, 4'hF, 4'hF);
  endtask

  task automatic test_reset_mid_run();
    int c;
    logic [NREQ-1:0] v;
    logic [WIDTH-1:0] frozen;
    logic quiet;
    set_job(2, 4'h3, 1'b0, 20);
    wait_gnt(c, v);
    req = '0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    frozen = cnt_count;
    #1;
    n_vec++;
    if (gnt !== '0 || done !== '0 || busy !== 1'b0 || res_count !== '0 || res_wraps !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: gnt %b done %b busy %b count %h wraps %h, expected all 0", gnt, done, busy, res_count, res_wraps);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done !== '0 || busy !== 1'b0 || cnt_count !== frozen) quiet = 1'b0;
    end
    n_vec++;
    if (!quiet) begin
      n_err++;
      $display("FAIL midrst_quiet: done %b busy %b counter %h, expected 0 0 %h", done, busy, cnt_count, frozen);
    end
    run_one("after_rst", 3, 4'h9, 1'b1, 2, 4'h7, 4'h0);
  endtask

  task automatic test_random();
    int gnt_cyc, done_cyc, idle_at, own, ptr, len;
    logic [WIDTH-1:0] e_cnt;
    logic [WRAPW-1:0] e_wr;
    logic [NREQ-1:0] eg, ed;
    logic eb;
    gnt_cyc = -10;
    done_cyc = -10;
    idle_at = 0;
    own = 0;
    ptr = 0;
    e_cnt = '0;
    e_wr = '0;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      eg = (cyc == gnt_cyc)  ? onehot(own) : '0;
      ed = (cyc == done_cyc) ? onehot(own) : '0;
      eb = (cyc >= gnt_cyc) && (cyc <= done_cyc);
      n_vec++;
      if (gnt !== eg) begin
        n_err++;
        $display("FAIL rnd_gnt cycle %0d: got %b expected %b", cyc, gnt, eg);
      end
      n_vec++;
      if (done !== ed) begin
        n_err++;
        $display("FAIL rnd_done cycle %0d: got %b expected %b", cyc, done, ed);
      end
      n_vec++;
      if (busy !== eb) begin
        n_err++;
        $display("FAIL rnd_busy cycle %0d: got %b expected %b", cyc, busy, eb);
      end
      if (cyc == done_cyc + 1) begin
        n_vec++;
        if (res_count !== e_cnt || res_wraps !== e_wr) begin
          n_err++;
          $display("FAIL rnd_res cycle %0d: count %h wraps %h, expected %h %h", cyc, res_count, res_wraps, e_cnt, e_wr);
        end
      end
      if (cyc == gnt_cyc) req[own] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && !(cyc == gnt_cyc && i == own) && $urandom_range(0, 5) == 0) begin
          len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
          set_job(i, WIDTH'($urandom), 1'($urandom), len);
        end
      end
      if (cyc >= idle_at && req != '0) begin
        own      = pick_rr(req, ptr);
        ptr      = (own + 1) % NREQ;
        len      = int'(req_len[own*LENW +: LENW]);
        gnt_cyc  = cyc + 1;
        done_cyc = cyc + 2 + len;
        idle_at  = done_cyc + 1;
        job_result(int'(req_load[own*WIDTH +: WIDTH]), req_down[own], len, e_cnt, e_wr);
      end
    end
    req = '0;
  endtask

  initial begin
    rst      = 1'b0;
    req      = '0;
    req_load = '0;
    req_down = '0;
    req_len  = '0;
    #1 rst = 1'b1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_zero_len();
    test_round_robin();
    test_saturate();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
